// File: rtl/qspi_host_master_pkg.sv
// Shared definitions for the QSPI host master: opcodes common with the bridge slave,
// FSM state encoding and fixed phase lengths.
package qspi_host_master_pkg;

  localparam logic [7:0] OPC_READ  = 8'hEB;
  localparam logic [7:0] OPC_WRITE = 8'h32;

  localparam int CMD_CYCLES  = 2;
  localparam int ADDR_CYCLES = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/qspi_host_sckgen.sv
// SCK generator: a half-period down-counter that toggles SCK on terminal count and
// flags the clock on which SCK rises, falls, or (while parked low) would have risen.
module qspi_host_sckgen #(
  parameter int CLKDIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic park_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o,
  output logic tc_stb_o
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tc;

  always_comb begin
    tc         = run_i && (cnt_q == '0);
    rise_stb_o = tc && !sck_q && !park_i;
    fall_stb_o = tc && sck_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    if (!run_i) begin
      // Idle keeps the counter preloaded so the first rise lands one half-period later.
      cnt_d = RELOAD;
      sck_d = 1'b0;
    end else if (tc) begin
      cnt_d = RELOAD;
      sck_d = sck_q ? 1'b0 : !park_i;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= RELOAD;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o    = sck_q;
  assign tc_stb_o = tc;

endmodule

// File: rtl/qspi_host_master.sv
// Wishbone-classic to quad-SPI host master, mode 0, MSB-first nibbles, one access in flight.
// Optional QSPI_HOST_DYN_DUMMY_EN adds dummy_i[7:0] to set the read dummy count per access.
//
// state | meaning
// IDLE  | waiting for cyc&stb, SCE high, stall low
// SETUP | SCE low, first opcode nibble on the bus, half-period before first rise
// CMD   | opcode nibbles
// ADDR  | 32-bit address nibbles
// WDATA | write data nibbles, master drives
// DUMMY | turnaround cycles, bus released
// RDATA | read nibbles sampled on SCK rise
// HOLD  | SCK low for one half-period before SCE rises (ack here)
// GAP   | SCE high for CS_IDLE clocks, still stalled
module qspi_host_master
  import qspi_host_master_pkg::*;
#(
  parameter int         ADDRBITS     = 26,
  parameter int         DATABITS     = 16,
  parameter int         CLKDIV       = 2,
  parameter int         DUMMY_CYCLES = 8,
  parameter logic [7:0] RD_OPCODE    = OPC_READ,
  parameter logic [7:0] WR_OPCODE    = OPC_WRITE,
  parameter int         CS_IDLE      = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDRBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic                spi_sck_o,
  output logic                spi_sce_o,
  output logic [3:0]          spi_io_o,
  input  logic [3:0]          spi_io_i,
  output logic                spi_io_oe
`ifdef QSPI_HOST_DYN_DUMMY_EN
  ,
  input  logic [7:0]          dummy_i
`endif
);

  localparam int SW        = 8 + 32 + DATABITS;
  localparam int DATA_NIBS = DATABITS / 4;
  localparam int GW        = $clog2(CS_IDLE + 1);

  state_e                state_q, state_d;
  logic [7:0]            nib_q, nib_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic [DATABITS-1:0]   rx_q, rx_d;
  logic [DATABITS-1:0]   dat_q, dat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [3:0]            io_q, io_d;
  logic                  we_q, we_d;
  logic                  sce_q, sce_d;
  logic                  oe_q, oe_d;
  logic                  ack_q, ack_d;
  logic                  stall_q, stall_d;
  logic                  cyc_lost_q, cyc_lost_d;
  logic                  accept, run, park;
  logic                  rise_stb, fall_stb, tc_stb;
  logic [7:0]            dummy_len;

  assign accept = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i && !stall_q;
  assign run    = (state_q != ST_IDLE) && (state_q != ST_GAP);
  assign park   = (state_q == ST_HOLD);

`ifdef QSPI_HOST_DYN_DUMMY_EN
  logic [7:0] dummy_q, dummy_d;

  always_comb begin
    dummy_d = dummy_q;
    if (accept) dummy_d = dummy_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) dummy_q <= 8'(DUMMY_CYCLES);
    else         dummy_q <= dummy_d;
  end

  assign dummy_len = dummy_q;
`else
  assign dummy_len = 8'(DUMMY_CYCLES);
`endif

  qspi_host_sckgen #(.CLKDIV(CLKDIV)) u_sckgen (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .run_i      (run),
    .park_i     (park),
    .sck_o      (spi_sck_o),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb),
    .tc_stb_o   (tc_stb)
  );

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    dat_d      = dat_q;
    gap_d      = gap_q;
    io_d       = io_q;
    we_d       = we_q;
    sce_d      = sce_q;
    oe_d       = oe_q;
    ack_d      = 1'b0;
    stall_d    = stall_q;
    cyc_lost_d = cyc_lost_q | (!wb_cyc_i && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SETUP;
          we_d       = wb_we_i;
          shift_d    = {(wb_we_i ? WR_OPCODE : RD_OPCODE), 32'(wb_adr_i), wb_dat_i};
          io_d       = wb_we_i ? WR_OPCODE[7:4] : RD_OPCODE[7:4];
          sce_d      = 1'b0;
          oe_d       = 1'b1;
          stall_d    = 1'b1;
          cyc_lost_d = 1'b0;
          nib_d      = 8'(CMD_CYCLES - 1);
        end
      end

      ST_SETUP: begin
        if (rise_stb) state_d = ST_CMD;
      end

      ST_CMD, ST_ADDR, ST_WDATA: begin
        if (fall_stb) begin
          shift_d = shift_q << 4;
          io_d    = shift_q[SW-5 -: 4];
          nib_d   = nib_q - 8'd1;
          if (nib_q == '0) begin
            if (state_q == ST_CMD) begin
              state_d = ST_ADDR;
              nib_d   = 8'(ADDR_CYCLES - 1);
            end else if (state_q == ST_WDATA) begin
              state_d = ST_HOLD;
            end else if (we_q) begin
              state_d = ST_WDATA;
              nib_d   = 8'(DATA_NIBS - 1);
            end else begin
              // Release the bus on the last address fall so the slave can turn it around.
              oe_d = 1'b0;
              io_d = 4'h0;
              if (dummy_len == '0) begin
                state_d = ST_RDATA;
                nib_d   = 8'(DATA_NIBS - 1);
              end else begin
                state_d = ST_DUMMY;
                nib_d   = dummy_len - 8'd1;
              end
            end
          end
        end
      end

      ST_DUMMY: begin
        if (fall_stb) begin
          nib_d = nib_q - 8'd1;
          if (nib_q == '0) begin
            state_d = ST_RDATA;
            nib_d   = 8'(DATA_NIBS - 1);
          end
        end
      end

      ST_RDATA: begin
        if (rise_stb) rx_d = (rx_q << 4) | DATABITS'(spi_io_i);
        if (fall_stb) begin
          nib_d = nib_q - 8'd1;
          if (nib_q == '0) state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (tc_stb) begin
          state_d = ST_GAP;
          sce_d   = 1'b1;
          oe_d    = 1'b0;
          io_d    = 4'h0;
          ack_d   = wb_cyc_i && !cyc_lost_q;
          gap_d   = GW'(CS_IDLE - 1);
          if (!we_q) dat_d = rx_q;
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          stall_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      nib_q      <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      dat_q      <= '0;
      gap_q      <= '0;
      io_q       <= '0;
      we_q       <= 1'b0;
      sce_q      <= 1'b1;
      oe_q       <= 1'b0;
      ack_q      <= 1'b0;
      stall_q    <= 1'b0;
      cyc_lost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      dat_q      <= dat_d;
      gap_q      <= gap_d;
      io_q       <= io_d;
      we_q       <= we_d;
      sce_q      <= sce_d;
      oe_q       <= oe_d;
      ack_q      <= ack_d;
      stall_q    <= stall_d;
      cyc_lost_q <= cyc_lost_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_stall_o = stall_q;
  assign spi_sce_o  = sce_q;
  assign spi_io_o   = io_q;
  assign spi_io_oe  = oe_q;

endmodule
